// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer: copies a 160-byte source page into OAM one byte per M-cycle
// and owns the memory address mux while the copy runs.
module oam_dma_ctrl #(
    parameter int unsigned XFER_LEN    = 160,
    parameter logic [15:0] DEST_BASE   = 16'hFE00,
    parameter logic [15:0] REG_ADDR    = 16'hFF46,
    parameter int unsigned START_DELAY = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  t_cycle_i,
    input  logic [15:0] cpu_addr_i,
    input  logic [7:0]  cpu_wdata_i,
    input  logic        cpu_wr_i,
    input  logic [7:0]  mem_rdata_i,
    output logic [15:0] dma_addr_o,
    output logic [7:0]  dma_wdata_o,
    output logic        dma_rd_o,
    output logic        dma_wr_o,
    output logic        mem_ctrl_sel_o,
    output logic        dma_active_o,
    output logic        cpu_blocked_o,
    output logic [7:0]  reg_rdata_o
);

    // state   | meaning
    // S_IDLE  | no transfer, CPU owns the bus
    // S_START | waiting out START_DELAY complete M-cycles after a trigger
    // S_XFER  | copying: read at t0/t1, write at t2/t3
    typedef enum logic [1:0] {S_IDLE, S_START, S_XFER} state_t;

    state_t     state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] src_hi_q, src_hi_d;
    logic [7:0] reg_q, reg_d;
    logic [7:0] wdata_q, wdata_d;
    logic       sel_q, sel_d;
    logic       armed_q, armed_d;
    logic [7:0] delay_q, delay_d;
    logic       trigger;
    logic       last_t;

    assign trigger = cpu_wr_i && (cpu_addr_i == REG_ADDR);
    assign last_t  = (t_cycle_i == 2'd3);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            idx_q    <= 8'h00;
            src_hi_q <= 8'h00;
            reg_q    <= 8'hFF;
            wdata_q  <= 8'h00;
            sel_q    <= 1'b0;
            armed_q  <= 1'b0;
            delay_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            src_hi_q <= src_hi_d;
            reg_q    <= reg_d;
            wdata_q  <= wdata_d;
            sel_q    <= sel_d;
            armed_q  <= armed_d;
            delay_q  <= delay_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        src_hi_d = src_hi_q;
        reg_d    = reg_q;
        wdata_d  = wdata_q;
        sel_d    = sel_q;
        armed_d  = armed_q;
        delay_d  = delay_q;
        case (state_q)
            S_START: begin
                // an M-cycle only counts if START already held at its t0
                if (t_cycle_i == 2'd0) armed_d = 1'b1;
                if (last_t && armed_q) begin
                    if (delay_q <= 8'd1) begin
                        state_d = S_XFER;
                        sel_d   = 1'b1;
                    end else begin
                        delay_d = delay_q - 8'd1;
                    end
                end
            end
            S_XFER: begin
                if (t_cycle_i == 2'd1) wdata_d = mem_rdata_i;
                if (last_t) begin
                    if (idx_q == 8'(XFER_LEN - 1)) begin
                        state_d = S_IDLE;
                        sel_d   = 1'b0;
                        idx_d   = 8'h00;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            default: ;
        endcase
        // a trigger overrides everything, including completion of the last byte
        if (trigger) begin
            reg_d    = cpu_wdata_i;
            src_hi_d = (cpu_wdata_i >= 8'hE0) ? (cpu_wdata_i - 8'h20) : cpu_wdata_i;
            state_d  = S_START;
            idx_d    = 8'h00;
            armed_d  = 1'b0;
            delay_d  = 8'(START_DELAY);
            sel_d    = sel_q;
        end
    end

    always_comb begin
        dma_rd_o   = 1'b0;
        dma_wr_o   = 1'b0;
        dma_addr_o = 16'h0000;
        if (state_q == S_XFER) begin
            if (!t_cycle_i[1]) begin
                dma_rd_o   = 1'b1;
                dma_addr_o = {src_hi_q, idx_q};
            end else begin
                dma_wr_o   = 1'b1;
                dma_addr_o = DEST_BASE + {8'h00, idx_q};
            end
        end
    end

    assign dma_wdata_o    = wdata_q;
    assign reg_rdata_o    = reg_q;
    assign mem_ctrl_sel_o = sel_q;
    assign dma_active_o   = (state_q != S_IDLE);
    assign cpu_blocked_o  = dma_active_o
                            && !(cpu_addr_i >= 16'hFF80 && cpu_addr_i <= 16'hFFFE)
                            && !trigger;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Randomized bench for oam_dma_ctrl: a memory model feeds reads, a monitor collects
// completed OAM writes and compares them with the sequence expected from each trigger.
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  tc;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_wr;
    logic [7:0]  mem_rdata;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_rd, dma_wr, mem_ctrl_sel, dma_active, cpu_blocked;
    logic [7:0]  reg_rdata;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [23:0] got_q[$];
    logic [23:0] exp_q[$];

    always #5 clk = ~clk;

    oam_dma_ctrl dut (
        .clk_i(clk), .rst_i(rst), .t_cycle_i(tc),
        .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata), .cpu_wr_i(cpu_wr),
        .mem_rdata_i(mem_rdata),
        .dma_addr_o(dma_addr), .dma_wdata_o(dma_wdata),
        .dma_rd_o(dma_rd), .dma_wr_o(dma_wr),
        .mem_ctrl_sel_o(mem_ctrl_sel), .dma_active_o(dma_active),
        .cpu_blocked_o(cpu_blocked), .reg_rdata_o(reg_rdata)
    );

    // page C1 holds i^5A; other pages differ so a wrong source page is visible
    function automatic logic [7:0] mem_f(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ (a[15:8] ^ 8'hC1);
    endfunction

    function automatic logic [7:0] src_page(input logic [7:0] v);
        return (v >= 8'hE0) ? v - 8'h20 : v;
    endfunction

    assign mem_rdata = mem_f(dma_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        tc     = tc + 2'd1;
        cyc++;
        cpu_wr = 1'b0;
        #1;
    endtask

    task automatic add_exp(input logic [7:0] page, input int n);
        for (int k = 0; k < n; k++)
            exp_q.push_back({16'hFE00 + 16'(k), mem_f({page, 8'(k)})});
    endtask

    task automatic clear_q();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic trig(input logic [7:0] v, input logic [1:0] tt, output int first_t0);
        for (int i = 0; i < 8 && tc != tt; i++) step();
        cpu_addr  = 16'hFF46;
        cpu_wdata = v;
        cpu_wr    = 1'b1;
        #1;
        chk("blk_ff46", 32'(cpu_blocked), 32'd0);
        first_t0 = cyc + 4 - int'(tt);
        step();
        cpu_addr = 16'h0000;
    endtask

    task automatic wait_writes(input int n, input logic [1:0] t);
        for (int i = 0; i < 2000 && !(got_q.size() == n && tc == t); i++) step();
        chk("reach_n", 32'(got_q.size()), 32'(n));
    endtask

    task automatic wait_done(input int first_t0, input bit restart);
        int rise  = -1;
        int fall  = -1;
        int drops = 0;
        logic [15:0] ba [6] = '{16'hFF90, 16'hFF80, 16'hFFFE, 16'hFF7F, 16'hFFFF, 16'hC000};
        logic        be [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 1200 && fall < 0; i++) begin
            step();
            if (i >= 300 && i < 306) begin
                cpu_addr = ba[i-300];
                #1;
                chk($sformatf("blk_%h", ba[i-300]), 32'(cpu_blocked), 32'(be[i-300]));
                cpu_addr = 16'h0000;
            end
            if (!dma_active) fall = cyc;
            else begin
                if (rise < 0 && mem_ctrl_sel) rise = cyc;
                if (restart && !mem_ctrl_sel) drops++;
            end
        end
        if (restart) chk("sel_held", 32'(drops), 32'd0);
        else         chk("sel_rise", 32'(rise), 32'(first_t0 + 4));
        chk("active_fall", 32'(fall), 32'(first_t0 + 644));
    endtask

    task automatic compare_writes();
        int n;
        chk("n_writes", 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("wr%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (dma_wr && tc == 2'd3) got_q.push_back({dma_addr, dma_wdata});
            if (dma_rd || dma_wr) begin
                chk("one_strobe", 32'(dma_rd & dma_wr), 32'd0);
                chk("strobe_sel", 32'(mem_ctrl_sel), 32'd1);
                chk("rd_phase", 32'(dma_rd), 32'(!tc[1]));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int ft;
        logic [7:0] v, v2;
        rst = 1'b1; tc = 2'd0; cpu_addr = 16'h0; cpu_wdata = 8'h0; cpu_wr = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            chk("idle", 32'({reg_rdata, mem_ctrl_sel, dma_rd, dma_wr, dma_active, dma_addr}),
                32'({8'hFF, 4'b0000, 16'h0000}));
        end

        clear_q();
        add_exp(8'hC1, 160);
        trig(8'hC1, 2'd2, ft);
        wait_done(ft, 1'b0);
        compare_writes();
        chk("reg_c1", 32'(reg_rdata), 32'h0C1);
        cpu_addr = 16'hC000;
        #1;
        chk("blk_done", 32'(cpu_blocked), 32'd0);
        cpu_addr = 16'h0000;

        for (int k = 0; k < 4; k++) begin
            v = (k == 0) ? 8'hF3 : (k == 1) ? 8'hE0 : 8'($urandom);
            clear_q();
            add_exp(src_page(v), 160);
            trig(v, 2'($urandom_range(0, 3)), ft);
            wait_done(ft, 1'b0);
            compare_writes();
            chk("reg_rd", 32'(reg_rdata), 32'(v));
        end

        // retrigger at byte 50: FE32 is never written, copy restarts from page 80
        clear_q();
        add_exp(8'hC1, 50);
        add_exp(8'h80, 160);
        trig(8'hC1, 2'($urandom_range(0, 3)), ft);
        wait_writes(50, 2'd0);
        trig(8'h80, 2'd0, ft);
        wait_done(ft, 1'b1);
        compare_writes();

        // retrigger on the edge the final byte completes
        v  = 8'($urandom);
        v2 = 8'($urandom);
        clear_q();
        add_exp(src_page(v), 160);
        add_exp(src_page(v2), 160);
        trig(v, 2'($urandom_range(0, 3)), ft);
        wait_writes(159, 2'd3);
        trig(v2, 2'd3, ft);
        wait_done(ft, 1'b1);
        compare_writes();
        chk("reg_final", 32'(reg_rdata), 32'(v2));

        // reset at byte 80, t2
        clear_q();
        trig(8'hC1, 2'($urandom_range(0, 3)), ft);
        wait_writes(80, 2'd2);
        rst = 1'b1;
        step();
        chk("rst_state", 32'({dma_wr, dma_rd, mem_ctrl_sel, dma_active}), 32'd0);
        chk("rst_reg", 32'(reg_rdata), 32'h0FF);
        chk("rst_addr", 32'(dma_addr), 32'd0);
        chk("rst_wdata", 32'(dma_wdata), 32'd0);
        rst = 1'b0;
        repeat (12) step();
        chk("rst_nowr", 32'(got_q.size()), 32'd80);
        chk("rst_idle", 32'({mem_ctrl_sel, dma_active}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
